// File: rtl/microcode_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | microcode_sequencer: microstep sequencer forming decode-ROM addresses    |
// | and gating the ROM control word. Optional macro: SEQ_SINGLE_STEP_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module microcode_sequencer #(
  parameter int STEP_W     = 4,
  parameter int INSTR_W    = 8,
  parameter int FLAG_W     = 4,
  parameter int CTRL_W     = 24,
  parameter int FINISH_BIT = 20,
  parameter logic [CTRL_W-1:0] CTRL_IDLE = {CTRL_W{1'b1}},
  parameter int CNT_W      = 16
) (
  input  logic                              i_nclk,
  input  logic                              i_nreset,
  input  logic [INSTR_W-1:0]                i_instrCode,
  input  logic [FLAG_W-1:0]                 i_flags,
  input  logic                              i_halt,
  output logic [FLAG_W+INSTR_W+STEP_W-1:0]  o_decodeAddr,
  input  logic [CTRL_W-1:0]                 i_decodeData,
  output logic [CTRL_W-1:0]                 o_ctrl,
  output logic [INSTR_W-1:0]                o_instr,
  output logic [STEP_W-1:0]                 o_step,
  output logic                              o_instrFinished,
  output logic                              o_fault,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                              i_stepMode,
  input  logic                              i_stepReq,
`endif
  output logic [CNT_W-1:0]                  o_instrCount
);

  localparam logic [STEP_W-1:0] MAX_STEP = {STEP_W{1'b1}};

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  state_t             state_q;
  logic [STEP_W-1:0]  step_q;
  logic [INSTR_W-1:0] instr_q;
  logic [FLAG_W-1:0]  flags_q;
  logic [CNT_W-1:0]   count_q;
  logic               fault_q;
  logic               advance;
  logic               fin;
  logic               gate;

  // Halt is not a stored state: it is simply RUN with advance suppressed.
`ifdef SEQ_SINGLE_STEP_EN
  assign advance = ~i_halt & (state_q == S_RUN) & (~i_stepMode | i_stepReq);
`else
  assign advance = ~i_halt & (state_q == S_RUN);
`endif

  assign fin  = ~i_decodeData[FINISH_BIT];
  assign gate = (state_q == S_RUN) & ~i_halt & i_nreset;

  assign o_instrFinished = advance & fin;
  assign o_ctrl          = gate ? i_decodeData : CTRL_IDLE;
  assign o_decodeAddr    = {flags_q, instr_q, step_q};
  assign o_instr         = instr_q;
  assign o_step          = step_q;
  assign o_fault         = fault_q;
  assign o_instrCount    = count_q;

  always_ff @(posedge i_nclk) begin
    if (!i_nreset) begin
      state_q <= S_RUN;
      step_q  <= '0;
      instr_q <= '0;
      flags_q <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else if (advance) begin
      if (fin) begin
        step_q  <= '0;
        flags_q <= '0;
        instr_q <= i_instrCode;
        count_q <= count_q + 1'b1;
      end else if (step_q != MAX_STEP) begin
        step_q  <= step_q + 1'b1;
        flags_q <= i_flags;
        instr_q <= i_instrCode;
      end else begin
        // Running off the end of the microstep space is a ROM bug; freeze until reset.
        state_q <= S_FAULT;
        fault_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// Randomized bench for microcode_sequencer against a behavioural model,
// with directed scenarios pinning the model to known literal values.
module tb_microcode_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic [7:0]  instr;
  logic [3:0]  flags;
  logic        halt;
  logic [23:0] data;
  logic        smode;
  logic        sreq;
  logic [15:0] addr;
  logic [23:0] ctrl;
  logic [7:0]  instr_o;
  logic [3:0]  step;
  logic        fin_o;
  logic        fault;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_step, m_instr, m_flags, m_count;
  bit m_fault;
  bit m_valid = 0;

  microcode_sequencer dut (
    .i_nclk          (clk),
    .i_nreset        (nreset),
    .i_instrCode     (instr),
    .i_flags         (flags),
    .i_halt          (halt),
    .o_decodeAddr    (addr),
    .i_decodeData    (data),
    .o_ctrl          (ctrl),
    .o_instr         (instr_o),
    .o_step          (step),
    .o_instrFinished (fin_o),
    .o_fault         (fault),
`ifdef SEQ_SINGLE_STEP_EN
    .i_stepMode      (smode),
    .i_stepReq       (sreq),
`endif
    .o_instrCount    (cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit model_adv();
    bit a;
    a = !halt && !m_fault;
`ifdef SEQ_SINGLE_STEP_EN
    a = a && (!smode || sreq);
`endif
    return a;
  endfunction

  task automatic compare_all();
    bit f;
    logic [23:0] ec;
    f  = (data[20] == 1'b0);
    ec = (!m_fault && !halt && nreset) ? data : 24'hFFFFFF;
    chk("ctrl", ctrl, ec);
    chk("fin", fin_o, model_adv() && f);
    chk("addr", addr, (m_flags << 12) + (m_instr << 4) + m_step);
    chk("instr", instr_o, m_instr);
    chk("step", step, m_step);
    chk("count", cnt, m_count);
    chk("fault", fault, m_fault);
  endtask

  task automatic model_update();
    if (!nreset) begin
      m_step = 0; m_instr = 0; m_flags = 0; m_count = 0; m_fault = 0;
    end else if (model_adv()) begin
      if (data[20] == 1'b0) begin
        m_step = 0; m_flags = 0; m_instr = instr;
        m_count = (m_count + 1) % 65536;
      end else if (m_step < 15) begin
        m_step = m_step + 1; m_flags = flags; m_instr = instr;
      end else begin
        m_fault = 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (m_valid) compare_all();
    @(posedge clk);
    model_update();
    m_valid = 1;
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    nreset = 0; instr = 8'h00; flags = 4'h0; halt = 0; data = 24'h1F3456;
    smode = 0; sreq = 0;
    repeat (2) cycle();
    chk("rst_step", step, 0);
    chk("rst_ctrl", ctrl, 24'hFFFFFF);
    chk("rst_count", cnt, 0);
    chk("rst_fault", fault, 0);

    // instr 0x12, finish at step 3
    nreset = 1; instr = 8'h12; flags = 4'hA; data = 24'h1ABCDE; settle();
    chk("run_ctrl", ctrl, 24'h1ABCDE);
    cycle();
    chk("seq_step1", step, 1);
    chk("seq_addr1", addr, 16'hA121);
    cycle(); chk("seq_step2", step, 2);
    cycle(); chk("seq_step3", step, 3);
    data = 24'h0ABCDE; settle();
    chk("seq_fin", fin_o, 1);
    cycle();
    chk("seq_step0", step, 0);
    chk("seq_count1", cnt, 1);
    chk("seq_addr0", addr, 16'h0120);

    // halt for 3 cycles at step 2
    data = 24'h1ABCDE;
    repeat (2) cycle();
    halt = 1; settle();
    chk("halt_ctrl", ctrl, 24'hFFFFFF);
    repeat (3) cycle();
    chk("halt_step", step, 2);
    halt = 0;
    cycle();
    chk("halt_resume", step, 3);

    // halt together with finish
    halt = 1; data = 24'h0ABCDE; settle();
    chk("hf_fin", fin_o, 0);
    cycle();
    chk("hf_step", step, 3);
    chk("hf_count", cnt, 1);
    halt = 0;
    cycle();
    chk("hf_step0", step, 0);
    chk("hf_count2", cnt, 2);

    // finish never asserted -> fault
    data = 24'h1ABCDE;
    repeat (15) cycle();
    chk("flt_step15", step, 15);
    chk("flt_pre", fault, 0);
    cycle();
    chk("flt_set", fault, 1);
    chk("flt_hold", step, 15);
    chk("flt_ctrl", ctrl, 24'hFFFFFF);
    halt = 1; repeat (2) cycle(); halt = 0;
    data = 24'h0ABCDE; repeat (2) cycle();
    chk("flt_sticky", fault, 1);
    chk("flt_cnt", cnt, 2);
    nreset = 0; cycle(); nreset = 1;
    chk("flt_clr", fault, 0);
    chk("flt_clr_step", step, 0);

`ifdef SEQ_SINGLE_STEP_EN
    smode = 1; data = 24'h1ABCDE;
    for (int i = 0; i < 10; i++) begin
      sreq = (i == 3 || i == 7);
      settle();
      if (i == 0) chk("ss_ctrl", ctrl, 24'h1ABCDE);
      cycle();
    end
    sreq = 0;
    chk("ss_step", step, 2);
    smode = 0;
`endif

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      nreset = ($urandom_range(0, 199) != 0);
      halt   = ($urandom_range(0, 7) == 0);
      instr  = 8'($urandom);
      flags  = 4'($urandom);
      data   = 24'($urandom);
      if ((c % 600) < 40) data[20] = 1'b1;
      else data[20] = ($urandom_range(0, 5) != 0);
`ifdef SEQ_SINGLE_STEP_EN
      smode = ($urandom_range(0, 3) == 0);
      sreq  = 1'($urandom);
`endif
      settle();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
